fd_queue: RTL

Parametrised decoupling queue between IF and ID, the successor to the single-entry IF/ID pipeline register. It buffers up to DEPTH fetched instructions with their branch-prediction metadata, so fetch keeps running while decode stalls. A valid/ready handshake replaces the old stall/hold behaviour, and a single flush empties the whole queue. Output fields read as zero (a bubble) whenever no entry is valid.

---
 rtl/fd_pkg.sv | 23 ++
 rtl/fd_queue.sv | 114 +++++++++++
 2 files changed

// File: rtl/fd_pkg.sv
// rtl/fd_pkg.sv - shared types and constants for the fetch/decode queue
//
// Purpose: defines the fetch entry record carried from IF to ID together with
// its branch-prediction metadata, and the all-zero bubble value.
// Ports: none (package).

package fd_pkg;

  localparam int XLEN      = 32;
  localparam int PHT_IDX_W = 8;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      instruction;
    logic                 pred_taken;
    logic [PHT_IDX_W-1:0] pht_idx;
    logic                 btb_hit;
    logic [XLEN-1:0]      btb_target;
  } fetch_entry_t;

  localparam fetch_entry_t FETCH_BUBBLE = '0;

endpackage

// File: rtl/fd_queue.sv
// rtl/fd_queue.sv - IF/ID decoupling queue with valid/ready handshake and flush
//
// Purpose: circular buffer of DEPTH fetch entries between fetch and decode.
// Fetch pushes with F_valid/F_ready, decode pops with D_valid/D_ready, flush
// empties the queue in one cycle. Outputs are all-zero when the queue is empty.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   flush                        discard all queued entries
//   F_valid / F_ready            fetch-side handshake
//   F_PC, F_instruction, F_btb_target, F_pred_taken, F_btb_hit, F_pht_idx
//                                fetch payload
//   D_valid / D_ready            decode-side handshake
//   D_PC, D_instruction, D_btb_target, D_pred_taken, D_btb_hit, D_pht_idx
//                                head payload (zero when D_valid is low)
//   count                        current occupancy

module fd_queue
  import fd_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int XLEN      = fd_pkg::XLEN,
  parameter int PHT_IDX_W = fd_pkg::PHT_IDX_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       F_valid,
  output logic                       F_ready,
  input  logic [XLEN-1:0]            F_PC,
  input  logic [XLEN-1:0]            F_instruction,
  input  logic [XLEN-1:0]            F_btb_target,
  input  logic                       F_pred_taken,
  input  logic                       F_btb_hit,
  input  logic [PHT_IDX_W-1:0]       F_pht_idx,
  output logic                       D_valid,
  input  logic                       D_ready,
  output logic [XLEN-1:0]            D_PC,
  output logic [XLEN-1:0]            D_instruction,
  output logic [XLEN-1:0]            D_btb_target,
  output logic                       D_pred_taken,
  output logic                       D_btb_hit,
  output logic [PHT_IDX_W-1:0]       D_pht_idx,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push;
  logic          pop;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head_entry;

  // Readiness comes only from occupancy, so a full queue refuses a push even
  // when decode drains the head in the same cycle.
  assign F_ready = (count < CW'(DEPTH));
  assign D_valid = (count != '0);

  assign push = F_valid && F_ready && !flush;
  assign pop  = D_valid && D_ready && !flush;

  always_comb begin
    wr_entry             = FETCH_BUBBLE;
    wr_entry.pc          = F_PC;
    wr_entry.instruction = F_instruction;
    wr_entry.pred_taken  = F_pred_taken;
    wr_entry.pht_idx     = F_pht_idx;
    wr_entry.btb_hit     = F_btb_hit;
    wr_entry.btb_target  = F_btb_target;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Flush leaves storage untouched; stale entries are hidden by D_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= FETCH_BUBBLE;
    end else if (push) begin
      mem[tail] <= wr_entry;
    end
  end

  assign head_entry = D_valid ? mem[head] : FETCH_BUBBLE;

  assign D_PC          = head_entry.pc;
  assign D_instruction = head_entry.instruction;
  assign D_pred_taken  = head_entry.pred_taken;
  assign D_pht_idx     = head_entry.pht_idx;
  assign D_btb_hit     = head_entry.btb_hit;
  assign D_btb_target  = head_entry.btb_target;

endmodule
